// File: rtl/sipo_deser_param_pkg.sv
// Shared types and defaults for the parametrised serial-to-parallel deserialiser.
package sipo_deser_param_pkg;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LANES = 1;
  localparam int unsigned DEF_DEPTH = 16;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_deser_param_fifo_sync_fwft.sv
// Single-clock show-ahead FIFO; head word drives rdata_c, zero when empty.
module sipo_deser_param_fifo_sync_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic                      full_c,
  output logic                      empty_c,
  output logic [WIDTH-1:0]          rdata_c,
  output logic [$clog2(DEPTH):0]    count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full_c;
    do_pop  = pop && !empty_c;
    rdata_c = empty_c ? '0 : mem[rd_ptr[AW-1:0]];
    count_c = wr_ptr - rd_ptr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !flush_i) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sipo_deser_param.sv
// Serial-to-parallel deserialiser: LANES-bit beats packed into WIDTH-bit words, buffered in a FIFO.
module sipo_deser_param
  import sipo_deser_param_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [LANES-1:0]          data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CW    = clog2_min1(BEATS);
  localparam int unsigned OW    = clog2_min1(WIDTH);
  localparam logic [CW-1:0]    LAST      = CW'(BEATS - 1);
  localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'((64'd1 << LANES) - 64'd1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;

  logic             last_c;
  logic             accept_c;
  logic             push_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic [OW-1:0]    idx_c;
  logic [OW-1:0]    off_c;
  logic [WIDTH-1:0] base_c;
  logic [WIDTH-1:0] word_c;

  // Last beat is only refused while the FIFO has no room for the finished word.
  always_comb begin
    last_c   = (cnt == LAST);
    ready_o  = !rst_i && !flush_i && !(last_c && fifo_full_c);
    accept_c = valid_i && ready_o;
    push_c   = accept_c && last_c;
  end

  // Current beat merged into the partial word at its lane slot.
  always_comb begin
    idx_c  = OW'(cnt) * OW'(LANES);
    off_c  = MSB_FIRST ? (OW'(WIDTH - LANES) - idx_c) : idx_c;
    base_c = (state == S_IDLE) ? '0 : sreg;
    word_c = (base_c & ~(LANE_MASK << off_c)) | (WIDTH'(data_i) << off_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (accept_c) begin
      if (last_c) begin
        state <= S_IDLE;
        cnt   <= '0;
        sreg  <= '0;
      end else begin
        state <= S_COLLECT;
        cnt   <= cnt + CW'(1);
        sreg  <= word_c;
      end
    end
  end

  sipo_deser_param_fifo_sync_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push    (push_c),
    .wdata   (word_c),
    .pop     (ready_i),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .rdata_c (data_o),
    .count_c (count_o)
  );

  assign valid_o = !fifo_empty_c;

endmodule

// File: tb/tb_sipo_deser_param.sv
// Self-checking bench: LSB/MSB 1-lane and 2-lane instances against a queue-based word model.
module tb_sipo_deser_param;

  localparam int unsigned D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, din, vin, rin;
  logic       rdy, vout;
  logic [7:0] dout;
  logic [4:0] cnt;
  logic       rdy_m, vout_m;
  logic [7:0] dout_m;
  logic [4:0] cnt_m;
  logic [1:0] d2;
  logic       v2, rdy_2, vout_2;
  logic [7:0] dout_2;
  logic [4:0] cnt_2;

  sipo_deser_param #(.WIDTH(8), .LANES(1), .DEPTH(16), .MSB_FIRST(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin), .ready_o(rdy),
    .data_o(dout), .valid_o(vout), .ready_i(rin), .count_o(cnt));

  sipo_deser_param #(.WIDTH(8), .LANES(1), .DEPTH(16), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin), .ready_o(rdy_m),
    .data_o(dout_m), .valid_o(vout_m), .ready_i(rin), .count_o(cnt_m));

  sipo_deser_param #(.WIDTH(8), .LANES(2), .DEPTH(16), .MSB_FIRST(1'b0)) dut_l2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(d2), .valid_i(v2), .ready_o(rdy_2),
    .data_o(dout_2), .valid_o(vout_2), .ready_i(rin), .count_o(cnt_2));

  // Reference: queue of finished words plus the bits gathered so far.
  logic [7:0] q[$];
  int         nb;
  logic [7:0] part;
  logic       exp_rdy, exp_v;
  logic [7:0] exp_d;
  int         exp_cnt;
  int         checks, errors;

  task automatic step(input logic r_st, input logic v, input logic d, input logic r, input logic f);
    @(negedge clk);
    rst = r_st; vin = v; din = d; rin = r; flush = f;
    #1;
    exp_rdy = !r_st && !f && !(nb == 7 && q.size() == D);
    exp_v   = (q.size() != 0);
    exp_d   = exp_v ? q[0] : 8'h00;
    exp_cnt = q.size();
    if (r_st || f) begin
      q.delete(); nb = 0; part = '0;
    end else begin
      if (exp_v && r) void'(q.pop_front());
      if (v && exp_rdy) begin
        part[nb] = d;
        nb++;
        if (nb == 8) begin q.push_back(part); nb = 0; part = '0; end
      end
    end
  endtask

  task automatic feed_word(input logic [7:0] w);
    for (int b = 0; b < 8; b++) step(1'b0, 1'b1, w[b], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy !== 1'b0 || rdy_m !== 1'b0 || rdy_2 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b%b want 000", rdy, rdy_m, rdy_2); end
    checks++; if (vout !== 1'b0 || vout_m !== 1'b0 || vout_2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b%b want 000", vout, vout_m, vout_2); end
    checks++; if (dout !== 8'h00 || dout_m !== 8'h00 || dout_2 !== 8'h00) begin errors++; $display("FAIL reset_data got %h %h %h want 00", dout, dout_m, dout_2); end
    checks++; if (cnt !== 5'd0 || cnt_m !== 5'd0 || cnt_2 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d %0d %0d want 0", cnt, cnt_m, cnt_2); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy !== 1'b1 || rdy_2 !== 1'b1) begin errors++; $display("FAIL release_ready got %b%b want 11", rdy, rdy_2); end
  endtask

  task automatic test_bit_order();
    logic [7:0] pat;
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, pat[i], 1'b0, 1'b0);
      checks++; if (vout !== 1'b0) begin errors++; $display("FAIL order_early_valid beat %0d got %b want 0", i, vout); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (vout !== 1'b1 || dout !== 8'h4D) begin errors++; $display("FAIL lsb_word got v=%b %h want v=1 4d", vout, dout); end
    checks++; if (vout_m !== 1'b1 || dout_m !== 8'hB2) begin errors++; $display("FAIL msb_word got v=%b %h want v=1 b2", vout_m, dout_m); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lanes2();
    logic [7:0] pat;
    pat = 8'h39;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v2 = 1'b1; d2 = pat[2*i +: 2];
      checks++; if (rdy_2 !== 1'b1 || vout_2 !== 1'b0) begin errors++; $display("FAIL l2_beat %0d got rdy=%b v=%b want 1 0", i, rdy_2, vout_2); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v2 = 1'b0; d2 = 2'b00;
    checks++; if (vout_2 !== 1'b1 || dout_2 !== 8'h39 || cnt_2 !== 5'd1) begin errors++; $display("FAIL l2_word got v=%b %h cnt=%0d want 1 39 1", vout_2, dout_2, cnt_2); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full();
    logic [7:0] w0, w1, x;
    for (int w = 0; w < 16; w++) begin
      x = 8'($urandom);
      if (w == 0) w0 = x;
      if (w == 1) w1 = x;
      feed_word(x);
    end
    x = 8'($urandom);
    for (int b = 0; b < 7; b++) step(1'b0, 1'b1, x[b], 1'b0, 1'b0);
    step(1'b0, 1'b1, x[7], 1'b0, 1'b0);
    checks++; if (cnt !== 5'd16 || rdy !== 1'b0) begin errors++; $display("FAIL full_stall got cnt=%0d rdy=%b want 16 0", cnt, rdy); end
    step(1'b0, 1'b1, x[7], 1'b1, 1'b0);
    checks++; if (rdy !== 1'b0 || dout !== w0) begin errors++; $display("FAIL full_no_bypass got rdy=%b %h want 0 %h", rdy, dout, w0); end
    step(1'b0, 1'b1, x[7], 1'b0, 1'b0);
    checks++; if (rdy !== 1'b1 || cnt !== 5'd15 || dout !== w1) begin errors++; $display("FAIL full_after_pop got rdy=%b cnt=%0d %h want 1 15 %h", rdy, cnt, dout, w1); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt !== 5'd16 || rdy !== 1'b1) begin errors++; $display("FAIL full_refill got cnt=%0d rdy=%b want 16 1", cnt, rdy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gaps();
    logic [7:0] pat;
    int hs;
    pat = 8'hA5;
    hs = 0;
    for (int c = 0; c < 64 && hs < 8; c++) begin
      if (c % 2 == 0) step(1'b0, 1'b1, pat[hs], 1'b0, 1'b0);
      else            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (vout !== 1'b0) begin errors++; $display("FAIL gap_early_valid cycle %0d got %b want 0", c, vout); end
      if (c % 2 == 0 && rdy === 1'b1) hs++;
    end
    checks++; if (hs != 8) begin errors++; $display("FAIL gap_handshakes got %0d want 8", hs); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (vout !== 1'b1 || dout !== 8'hA5 || cnt !== 5'd1) begin errors++; $display("FAIL gap_word got v=%b %h cnt=%0d want 1 a5 1", vout, dout, cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    logic [7:0] pat;
    for (int w = 0; w < 4; w++) feed_word(8'($urandom));
    for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt !== 5'd4) begin errors++; $display("FAIL flush_pre_count got %0d want 4", cnt); end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", rdy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt !== 5'd0 || vout !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL flush_clear got cnt=%0d v=%b %h want 0 0 00", cnt, vout, dout); end
    pat = 8'h3C;
    feed_word(pat);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (vout !== 1'b1 || dout !== 8'h3C || cnt !== 5'd1) begin errors++; $display("FAIL flush_next_word got v=%b %h cnt=%0d want 1 3c 1", vout, dout, cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_push_pop_reset();
    logic [7:0] w1, y, z;
    for (int w = 0; w < 5; w++) begin
      y = 8'($urandom);
      if (w == 1) w1 = y;
      feed_word(y);
    end
    y = 8'($urandom);
    for (int b = 0; b < 7; b++) step(1'b0, 1'b1, y[b], 1'b0, 1'b0);
    step(1'b0, 1'b1, y[7], 1'b1, 1'b0);
    checks++; if (cnt !== 5'd5 || rdy !== 1'b1) begin errors++; $display("FAIL pp_before got cnt=%0d rdy=%b want 5 1", cnt, rdy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt !== 5'd5 || dout !== w1) begin errors++; $display("FAIL pp_after got cnt=%0d %h want 5 %h", cnt, dout, w1); end
    for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", rdy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (vout !== 1'b0 || dout !== 8'h00 || cnt !== 5'd0 || rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_word got v=%b %h cnt=%0d rdy=%b want 0 00 0 1", vout, dout, cnt, rdy); end
    z = 8'($urandom);
    feed_word(z);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (vout !== 1'b1 || dout !== z || cnt !== 5'd1) begin errors++; $display("FAIL rst_next_word got v=%b %h cnt=%0d want 1 %h 1", vout, dout, cnt, z); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic v, d, r, f, rs;
    for (int c = 0; c < 3000; c++) begin
      v  = ($urandom % 4) != 0;
      d  = 1'($urandom);
      r  = (c < 1500) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      f  = ($urandom % 250) == 0;
      rs = ($urandom % 600) == 0;
      step(rs, v, d, r, f);
      checks++;
      if (rdy !== exp_rdy || vout !== exp_v || dout !== exp_d || cnt !== 5'(exp_cnt)) begin
        errors++;
        $display("FAIL random cycle %0d got rdy=%b v=%b d=%h cnt=%0d want rdy=%b v=%b d=%h cnt=%0d",
                 c, rdy, vout, dout, cnt, exp_rdy, exp_v, exp_d, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = 1'b0; vin = 1'b0; rin = 1'b0;
    d2 = 2'b00; v2 = 1'b0;
    nb = 0; part = '0; checks = 0; errors = 0;
    test_reset();
    test_bit_order();
    test_lanes2();
    test_full();
    test_gaps();
    test_flush();
    test_push_pop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
